// File: rtl/whack_pkg.sv
// Shared types and helpers for the Whac-A-Mole round sequencer.
// Holds the phase encoding and the per-round show-length rule.
package whack_pkg;

  localparam int NUM_HOLES_DEFAULT = 18;
  localparam int HOLE_IDX_W        = $clog2(NUM_HOLES_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2,
    DONE = 2'd3
  } state_t;

  // Show length shrinks by step each round.
  // A subtraction that would wrap below zero clamps to the floor.
  function automatic logic [31:0] show_ticks(
    input logic [31:0] round,
    input logic [31:0] init_ticks,
    input logic [31:0] step_ticks,
    input logic [31:0] min_ticks
  );
    logic [31:0] dec;
    logic [31:0] len;
    dec = round * step_ticks;
    if (dec > init_ticks) begin
      len = min_ticks;
    end else begin
      len = init_ticks - dec;
      if (len < min_ticks) len = min_ticks;
    end
    return len;
  endfunction

endpackage

// File: rtl/hit_scorer.sv
// Scores per-hole hit rises against the live mole bitmap.
// Tracks already-whacked holes and keeps two saturating counters.
module hit_scorer #(
  parameter int NUMBER_OF_HOLES = 18,
  parameter int SCORE_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_mask,
  input  logic                       clear_score,
  input  logic [NUMBER_OF_HOLES-1:0] hit,
  input  logic [NUMBER_OF_HOLES-1:0] mole_positions,
  output logic [SCORE_WIDTH-1:0]     score,
  output logic [SCORE_WIDTH-1:0]     misses
);

  localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_WIDTH) - 32'd1;

  logic [NUMBER_OF_HOLES-1:0] hit_q;
  logic [NUMBER_OF_HOLES-1:0] whacked_q, whacked_d;
  logic [NUMBER_OF_HOLES-1:0] rise, valid, miss;
  logic [SCORE_WIDTH-1:0]     score_q, score_d;
  logic [SCORE_WIDTH-1:0]     misses_q, misses_d;
  logic [31:0]                n_valid, n_miss;
  logic [31:0]                score_sum, misses_sum;

  always_comb begin
    rise  = hit & ~hit_q;
    valid = '0;
    miss  = '0;
    if (enable) begin
      valid = rise & mole_positions & ~whacked_q;
      miss  = rise & ~mole_positions;
    end
    n_valid = '0;
    n_miss  = '0;
    for (int i = 0; i < NUMBER_OF_HOLES; i++) begin
      n_valid = n_valid + 32'(valid[i]);
      n_miss  = n_miss + 32'(miss[i]);
    end
    score_sum  = 32'(score_q) + n_valid;
    misses_sum = 32'(misses_q) + n_miss;
    score_d    = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_WIDTH-1:0] : score_sum[SCORE_WIDTH-1:0];
    misses_d   = (misses_sum > SCORE_MAX) ? SCORE_MAX[SCORE_WIDTH-1:0] : misses_sum[SCORE_WIDTH-1:0];
    whacked_d  = whacked_q | valid;
    if (clear_mask) whacked_d = '0;
    if (clear_score) begin
      score_d  = '0;
      misses_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q     <= '0;
      whacked_q <= '0;
      score_q   <= '0;
      misses_q  <= '0;
    end else begin
      hit_q     <= hit;
      whacked_q <= whacked_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
    end
  end

  assign score  = score_q;
  assign misses = misses_q;

endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer: times show/hide phases, shortens each show, counts rounds.
// Phase is visible on the registered outputs: mole_clk=SHOW, busy&~mole_clk=HIDE, game_over=DONE.
module mole_round_controller
  import whack_pkg::*;
#(
  parameter int NUMBER_OF_HOLES  = NUM_HOLES_DEFAULT,
  parameter int NUMBER_OF_ROUNDS = 20,
  parameter int SHOW_TICKS_INIT  = 50_000_000,
  parameter int SHOW_TICKS_STEP  = 2_000_000,
  parameter int SHOW_TICKS_MIN   = 10_000_000,
  parameter int HIDE_TICKS       = 25_000_000,
  parameter int SCORE_WIDTH      = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [NUMBER_OF_HOLES-1:0]            hit,
  input  logic [NUMBER_OF_HOLES-1:0]            mole_positions,
  output logic                                  mole_clk,
  output logic                                  busy,
  output logic                                  game_over,
  output logic [$clog2(NUMBER_OF_ROUNDS+1)-1:0] round,
  output logic [SCORE_WIDTH-1:0]                score,
  output logic [SCORE_WIDTH-1:0]                misses
);

  localparam int RW = $clog2(NUMBER_OF_ROUNDS + 1);

  state_t        state_q;
  logic [31:0]   cnt_q;
  logic [RW-1:0] round_q;
  logic          mole_clk_q, busy_q, game_over_q;

  logic          start_ok, last_tick, final_round, enter_show;
  logic [RW-1:0] next_round;

  // start is a one-cycle pulse with no ready: accepted only in IDLE/DONE, dropped otherwise.
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_tick   = (cnt_q == 32'd1);
  assign next_round  = round_q + RW'(1);
  assign final_round = (next_round == RW'(NUMBER_OF_ROUNDS));
  assign enter_show  = start_ok || ((state_q == HIDE) && last_tick && !final_round);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      round_q     <= '0;
      mole_clk_q  <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= SHOW;
            cnt_q       <= 32'(SHOW_TICKS_INIT);
            round_q     <= '0;
            mole_clk_q  <= 1'b1;
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        SHOW: begin
          if (last_tick) begin
            state_q    <= HIDE;
            cnt_q      <= 32'(HIDE_TICKS);
            mole_clk_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        HIDE: begin
          if (last_tick) begin
            round_q <= next_round;
            if (final_round) begin
              state_q     <= DONE;
              cnt_q       <= '0;
              busy_q      <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              state_q    <= SHOW;
              cnt_q      <= show_ticks(32'(next_round), 32'(SHOW_TICKS_INIT),
                                       32'(SHOW_TICKS_STEP), 32'(SHOW_TICKS_MIN));
              mole_clk_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hit_scorer #(
    .NUMBER_OF_HOLES(NUMBER_OF_HOLES),
    .SCORE_WIDTH    (SCORE_WIDTH)
  ) u_hit_scorer (
    .clk           (clk),
    .reset         (reset),
    .enable        (state_q == SHOW),
    .clear_mask    (enter_show),
    .clear_score   (start_ok),
    .hit           (hit),
    .mole_positions(mole_positions),
    .score         (score),
    .misses        (misses)
  );

  assign mole_clk  = mole_clk_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign round     = round_q;

endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: timeline/score reference model plus directed cadence,
// scoring, saturation, ignored-start and reset scenarios, then randomized games.
module tb_mole_round_controller;

  localparam int NH   = 18;
  localparam int NR   = 5;
  localparam int INIT = 10;
  localparam int STEP = 3;
  localparam int MINT = 4;
  localparam int HIDE = 5;
  localparam int SW   = 4;
  localparam int RW   = $clog2(NR + 1);
  localparam int SAT  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [NH-1:0] hit, mole_positions;
  logic          mole_clk, busy, game_over;
  logic [RW-1:0] round;
  logic [SW-1:0] score, misses;

  always #5 clk = ~clk;

  mole_round_controller #(
    .NUMBER_OF_HOLES (NH),
    .NUMBER_OF_ROUNDS(NR),
    .SHOW_TICKS_INIT (INIT),
    .SHOW_TICKS_STEP (STEP),
    .SHOW_TICKS_MIN  (MINT),
    .HIDE_TICKS      (HIDE),
    .SCORE_WIDTH     (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .hit           (hit),
    .mole_positions(mole_positions),
    .mole_clk      (mole_clk),
    .busy          (busy),
    .game_over     (game_over),
    .round         (round),
    .score         (score),
    .misses        (misses)
  );

  typedef struct packed {
    logic          mole_clk;
    logic          busy;
    logic          game_over;
    logic [RW-1:0] round;
  } phase_t;

  // Reference model: a whole game is pre-expanded into a per-cycle timeline.
  phase_t        tl_q[$];
  phase_t        cur;
  int unsigned   m_score, m_misses;
  logic [NH-1:0] m_hit_q, m_whacked;
  logic          mclk_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int show_len(input int r);
    int s;
    s = INIT - r * STEP;
    return (s < MINT) ? MINT : s;
  endfunction

  task automatic build_timeline();
    phase_t p;
    tl_q.delete();
    for (int r = 0; r < NR; r++) begin
      p = '{mole_clk: 1'b1, busy: 1'b1, game_over: 1'b0, round: RW'(r)};
      for (int i = 0; i < show_len(r); i++) tl_q.push_back(p);
      p.mole_clk = 1'b0;
      for (int i = 0; i < HIDE; i++) tl_q.push_back(p);
    end
    p = '{mole_clk: 1'b0, busy: 1'b0, game_over: 1'b1, round: RW'(NR)};
    tl_q.push_back(p);
  endtask

  // Advance model and DUT by one clock, then compare all outputs.
  task automatic step();
    phase_t nxt;
    if (reset) begin
      nxt = '0;
      m_score = 0; m_misses = 0; m_hit_q = '0; m_whacked = '0;
      tl_q.delete();
    end else begin
      if (cur.mole_clk) begin
        for (int h = 0; h < NH; h++) begin
          if (hit[h] && !m_hit_q[h]) begin
            if (!mole_positions[h]) m_misses++;
            else if (!m_whacked[h]) begin
              m_score++;
              m_whacked[h] = 1'b1;
            end
          end
        end
      end
      if (m_score > SAT) m_score = SAT;
      if (m_misses > SAT) m_misses = SAT;
      m_hit_q = hit;
      nxt = cur;
      if (!cur.busy && start) begin
        build_timeline();
        m_score = 0;
        m_misses = 0;
      end
      if (tl_q.size() > 0) nxt = tl_q.pop_front();
      if (nxt.mole_clk && !cur.mole_clk) m_whacked = '0;
    end
    cur = nxt;
    @(posedge clk);
    #1;
    check("mole_clk", 32'(mole_clk), 32'(cur.mole_clk));
    check("busy", 32'(busy), 32'(cur.busy));
    check("game_over", 32'(game_over), 32'(cur.game_over));
    check("round", 32'(round), 32'(cur.round));
    check("score", 32'(score), m_score);
    check("misses", 32'(misses), m_misses);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int budget;
    budget = 200;
    while (!game_over && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check(tag, 32'(game_over), 32'd1);
  endtask

  initial begin
    int exp_runs[5];
    int runs[$];
    int gaps[$];
    int run_len, budget;
    exp_runs = '{10, 7, 4, 4, 4};

    reset = 1'b1; start = 1'b0; hit = '0; mole_positions = '0;
    cur = '0; m_score = 0; m_misses = 0; m_hit_q = '0; m_whacked = '0;
    step();
    step();
    check("rst_mole_clk", 32'(mole_clk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_round", 32'(round), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    reset = 1'b0;
    step();

    // Cadence and show-length floor.
    pulse_start();
    mclk_log.push_back(mole_clk);
    for (int i = 0; i < 59; i++) begin
      step();
      mclk_log.push_back(mole_clk);
    end
    run_len = 0;
    for (int i = 0; i < mclk_log.size(); i++) begin
      if (mclk_log[i]) begin
        if (run_len < 0) begin gaps.push_back(-run_len); run_len = 0; end
        run_len++;
      end else begin
        if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end
        run_len--;
      end
    end
    check("show_count", 32'(runs.size()), 32'd5);
    for (int i = 0; i < 5 && i < runs.size(); i++) check("show_width", 32'(runs[i]), 32'(exp_runs[i]));
    for (int i = 0; i < gaps.size(); i++) check("hide_gap", 32'(gaps[i]), 32'(HIDE));
    check("end_game_over", 32'(game_over), 32'd1);
    check("end_round", 32'(round), 32'(NR));

    // Valid, repeat, empty and simultaneous hits.
    mole_positions = 18'h00005;
    pulse_start();
    begin
      logic [NH-1:0] seq[10];
      seq = '{18'h0, 18'h0, 18'h1, 18'h0, 18'h1, 18'h0, 18'h4, 18'h0, 18'h2, 18'h0};
      for (int i = 0; i < 10; i++) begin
        hit = seq[i];
        step();
      end
    end
    check("dir_score", 32'(score), 32'd2);
    check("dir_misses", 32'(misses), 32'd1);
    budget = 30;
    while (!mole_clk && budget > 0) begin step(); budget--; end
    if (budget == 0) check("wait_show", 32'(mole_clk), 32'd1);
    hit = 18'h7;
    step();
    hit = '0;
    step();
    check("multi_score", 32'(score), 32'd4);
    check("multi_misses", 32'(misses), 32'd2);
    wait_done("wait_done_1");

    // Miss saturation.
    mole_positions = '0;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      hit = NH'(1) << (i % NH);
      step();
    end
    hit = '0;
    step();
    check("sat_misses", 32'(misses), 32'(SAT));
    check("sat_score", 32'(score), 32'd0);
    wait_done("wait_done_2");

    // Ignored start in SHOW, reset in HIDE, then a fresh game.
    pulse_start();
    step(); step(); step();
    pulse_start();
    budget = 30;
    while (!(busy && !mole_clk) && budget > 0) begin step(); budget--; end
    if (budget == 0) check("wait_hide", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mole_clk", 32'(mole_clk), 32'd0);
    check("mid_rst_round", 32'(round), 32'd0);
    step();
    pulse_start();
    for (int i = 0; i < 60; i++) step();
    check("replay_game_over", 32'(game_over), 32'd1);

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      pulse_start();
      for (int i = 0; i < 70; i++) begin
        mole_positions = NH'($urandom());
        hit = ($urandom_range(0, 2) == 0) ? NH'($urandom() & $urandom() & $urandom()) : '0;
        start = ($urandom_range(0, 19) == 0);
        reset = ($urandom_range(0, 149) == 0);
        step();
      end
      start = 1'b0;
      reset = 1'b0;
      hit = '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
